imem_boot_loader: RTL

- Owns the 2048 x 17-bit instruction memory's single address port and shares it between the CPU fetch path and a byte-serial boot loader (UART/SPI receiver).
- In RUN, CPU fetches pass straight through to IM.
- In LOAD, the CPU is stalled while the block assembles 17-bit instructions from a byte stream and writes them to consecutive IM addresses from 0.
- Sits between the fetch stage, the serial receiver and IM.

---
 rtl/imem_boot_loader.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader
// Purpose  : Shares the instruction-memory port between CPU fetch and a
//            byte-serial boot loader that writes 17-bit words from address 0.
// Revision : 1.0 - initial release
// ============================================================================
module imem_boot_loader #(
    parameter bit BOOT_ON_RESET = 1'b1,
    parameter int ADDR_W        = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rd_en,
    output logic              cpu_stall,
    input  logic              load_req,
    input  logic [7:0]        byte_in,
    input  logic              byte_vld,
    output logic              byte_rdy,
    output logic [ADDR_W-1:0] im_addr,
    output logic              im_rd_en,
    output logic              im_we,
    output logic [16:0]       im_wdata,
    output logic              boot_done,
    output logic              fmt_err
);

    localparam int c_HI_W  = ADDR_W - 8;
    localparam int c_REM_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_RUN   = 3'd0,
        S_HDR0  = 3'd1,
        S_HDR1  = 3'd2,
        S_B0    = 3'd3,
        S_B1    = 3'd4,
        S_B2    = 3'd5,
        S_WRITE = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    localparam state_t c_RESET_STATE = BOOT_ON_RESET ? S_HDR0 : S_RUN;

    state_t               r_state;
    state_t               w_next_state;
    logic [ADDR_W-1:0]    r_wr_addr;
    logic [c_REM_W-1:0]   r_remaining;
    logic [7:0]           r_cnt_lo;
    logic [16:0]          r_wdata;
    logic                 r_fmt_err;
    logic                 w_accept;
    logic [ADDR_W-1:0]    w_hdr_cnt;
    logic                 w_hdr_ovf;

    assign w_accept  = byte_vld & byte_rdy;
    assign w_hdr_cnt = {byte_in[c_HI_W-1:0], r_cnt_lo};
    // Header bits above the address width cannot be represented and are dropped.
    assign w_hdr_ovf = |(byte_in >> c_HI_W);

    assign im_wdata = r_wdata;
    assign fmt_err  = r_fmt_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_RESET_STATE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        cpu_stall    = 1'b1;
        byte_rdy     = 1'b0;
        im_addr      = r_wr_addr;
        im_rd_en     = 1'b0;
        im_we        = 1'b0;
        boot_done    = 1'b0;
        case (r_state)
            S_RUN: begin
                cpu_stall = 1'b0;
                im_addr   = cpu_addr;
                im_rd_en  = cpu_rd_en;
                if (load_req) w_next_state = S_HDR0;
            end
            S_HDR0: begin
                byte_rdy = 1'b1;
                if (byte_vld) w_next_state = S_HDR1;
            end
            S_HDR1: begin
                byte_rdy = 1'b1;
                if (byte_vld) w_next_state = S_B0;
            end
            S_B0: begin
                byte_rdy = 1'b1;
                if (byte_vld) w_next_state = S_B1;
            end
            S_B1: begin
                byte_rdy = 1'b1;
                if (byte_vld) w_next_state = S_B2;
            end
            S_B2: begin
                byte_rdy = 1'b1;
                if (byte_vld) w_next_state = S_WRITE;
            end
            S_WRITE: begin
                im_we        = 1'b1;
                w_next_state = (r_remaining == c_REM_W'(1)) ? S_DONE : S_B0;
            end
            S_DONE: begin
                boot_done    = 1'b1;
                w_next_state = S_RUN;
            end
            default: w_next_state = c_RESET_STATE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_addr   <= '0;
            r_remaining <= '0;
            r_cnt_lo    <= '0;
            r_wdata     <= '0;
            r_fmt_err   <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (load_req) begin
                        r_wr_addr <= '0;
                        r_fmt_err <= 1'b0;
                    end
                end
                S_HDR0: if (w_accept) r_cnt_lo <= byte_in;
                S_HDR1: begin
                    if (w_accept) begin
                        // Header holds count-1, so remaining spans 1..2**ADDR_W.
                        r_remaining <= {1'b0, w_hdr_cnt} + c_REM_W'(1);
                        if (w_hdr_ovf) r_fmt_err <= 1'b1;
                    end
                end
                S_B0: if (w_accept) r_wdata[7:0] <= byte_in;
                S_B1: if (w_accept) r_wdata[15:8] <= byte_in;
                S_B2: begin
                    if (w_accept) begin
                        r_wdata[16] <= byte_in[0];
                        if (|byte_in[7:1]) r_fmt_err <= 1'b1;
                    end
                end
                S_WRITE: begin
                    r_wr_addr   <= r_wr_addr + ADDR_W'(1);
                    r_remaining <= r_remaining - c_REM_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
